// File: rtl/branch_predictor_bht.sv
// Branch predictor with a bimodal table of saturating counters (BHT).
// Predicts next-PC and a taken flag for the instruction at pc_cur; the ROB
// trains the table at commit. JAL is always taken to its direct target,
// B-type follows the counter MSB, everything else (incl. JALR) falls through.
// Optional gshare indexing is enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor_bht #(
  parameter int ADDR_W    = 32,
  parameter int INS_W     = 32,
  parameter int BHT_IDX_W = 8,
  parameter int CNT_W     = 2,
  parameter int GHR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic [INS_W-1:0]  ins_cur,
  input  logic              fetch_valid,
  output logic [ADDR_W-1:0] pc_pred,
  output logic              predict_jump_to_dispatcher,
  input  logic              enable_from_rob,
  input  logic              if_jump,
  input  logic [ADDR_W-1:0] train_pc
`ifdef BRANCH_PREDICTOR_GSHARE_EN
  ,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic [GHR_W-1:0]  train_ghr,
  input  logic              train_mispredict
`endif
);

  localparam int              ENTRIES   = 1 << BHT_IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [6:0]      OP_JAL    = 7'b1101111;
  localparam logic [6:0]      OP_BRANCH = 7'b1100011;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  logic [ENTRIES-1:0][CNT_W-1:0] bht;
  logic [BHT_IDX_W-1:0]          lookup_idx;
  logic [BHT_IDX_W-1:0]          train_idx;
  logic [CNT_W-1:0]              lookup_cnt;
  logic                          is_jal;
  logic                          is_branch;
  logic                          bht_taken;
  logic signed [20:0]            imm_j_raw;
  logic signed [12:0]            imm_b_raw;
  logic signed [ADDR_W-1:0]      imm_j;
  logic signed [ADDR_W-1:0]      imm_b;
  logic                          unused_bits;

  assign is_jal    = (ins_cur[6:0] == OP_JAL);
  assign is_branch = (ins_cur[6:0] == OP_BRANCH);

  assign imm_j_raw = {ins_cur[31], ins_cur[19:12], ins_cur[20], ins_cur[30:21], 1'b0};
  assign imm_b_raw = {ins_cur[31], ins_cur[7], ins_cur[30:25], ins_cur[11:8], 1'b0};
  assign imm_j     = {{(ADDR_W-21){imm_j_raw[20]}}, imm_j_raw};
  assign imm_b     = {{(ADDR_W-13){imm_b_raw[12]}}, imm_b_raw};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign lookup_idx  = pc_cur[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);
  assign train_idx   = train_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(train_ghr);
  assign pred_ghr    = ghr;
  assign unused_bits = ^{train_pc, train_ghr};

  // Global history: mispredict recovery beats the speculative shift on fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (rdy) begin
      if (enable_from_rob && train_mispredict) begin
        ghr <= {train_ghr[GHR_W-2:0], if_jump};
      end else if (fetch_valid && is_branch) begin
        ghr <= {ghr[GHR_W-2:0], bht_taken};
      end
    end
  end
`else
  assign lookup_idx  = pc_cur[BHT_IDX_W+1:2];
  assign train_idx   = train_pc[BHT_IDX_W+1:2];
  assign unused_bits = ^{train_pc, fetch_valid};
`endif

  assign lookup_cnt = bht[lookup_idx];
  assign bht_taken  = lookup_cnt[CNT_W-1];

  // Counter table: reset to weakly-not-taken, one saturating update per commit
  always_ff @(posedge clk) begin
    if (rst) begin
      bht <= {ENTRIES{CNT_INIT}};
    end else if (rdy && enable_from_rob) begin
      bht[train_idx] <= if_jump ? sat_inc(bht[train_idx]) : sat_dec(bht[train_idx]);
    end
  end

  // Next-PC selection from the decoded opcode and the looked-up counter
  always_comb begin
    pc_pred                    = pc_cur + ADDR_W'(4);
    predict_jump_to_dispatcher = 1'b0;
    if (is_jal) begin
      pc_pred                    = pc_cur + imm_j;
      predict_jump_to_dispatcher = 1'b1;
    end else if (is_branch && bht_taken) begin
      pc_pred                    = pc_cur + imm_b;
      predict_jump_to_dispatcher = 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Testbench for branch_predictor_bht: directed scenarios followed by a
// randomized run against a behavioural model (integer counters, plain
// arithmetic immediates). Gshare checks compile in with BRANCH_PREDICTOR_GSHARE_EN.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_cur;
  logic [31:0] ins_cur;
  logic        fetch_valid;
  logic [31:0] pc_pred;
  logic        predict_jump_to_dispatcher;
  logic        enable_from_rob;
  logic        if_jump;
  logic [31:0] train_pc;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [7:0]  pred_ghr;
  logic [7:0]  train_ghr;
  logic        train_mispredict;
`endif

  int checks   = 0;
  int failures = 0;

  int cnt_m [256];
  int ghr_m;

  localparam logic [31:0] BEQ  = 32'h00000463;
  localparam logic [31:0] JAL  = 32'hFF9FF0EF;
  localparam logic [31:0] JALR = 32'h000080E7;

  branch_predictor_bht dut (
    .clk                        (clk),
    .rst                        (rst),
    .rdy                        (rdy),
    .pc_cur                     (pc_cur),
    .ins_cur                    (ins_cur),
    .fetch_valid                (fetch_valid),
    .pc_pred                    (pc_pred),
    .predict_jump_to_dispatcher (predict_jump_to_dispatcher),
    .enable_from_rob            (enable_from_rob),
    .if_jump                    (if_jump),
    .train_pc                   (train_pc)
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    ,
    .pred_ghr                   (pred_ghr),
    .train_ghr                  (train_ghr),
    .train_mispredict           (train_mispredict)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference prediction computed from the rules with integer arithmetic
  function automatic void model_pred(input logic [31:0] pc, input logic [31:0] ins,
                                     output logic tk, output logic [31:0] npc);
    int imm;
    int idx;
    idx = int'((pc >> 2) & 32'hFF);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    idx = idx ^ ghr_m;
`endif
    tk  = 1'b0;
    npc = pc + 32'd4;
    if (ins[6:0] == 7'h6F) begin
      imm = (int'(ins[19:12]) << 12) + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1);
      if (ins[31]) imm = imm - (1 << 20);
      tk  = 1'b1;
      npc = pc + 32'(imm);
    end else if (ins[6:0] == 7'h63 && cnt_m[idx] >= 2) begin
      imm = (int'(ins[7]) << 11) + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
      if (ins[31]) imm = imm - (1 << 12);
      tk  = 1'b1;
      npc = pc + 32'(imm);
    end
  endfunction

  // Advance the model with the inputs seen at this edge, then take the edge
  task automatic tick();
    logic        tk;
    logic [31:0] np;
    int          ti;
    model_pred(pc_cur, ins_cur, tk, np);
    ti = int'((train_pc >> 2) & 32'hFF);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    ti = ti ^ int'(train_ghr);
`endif
    if (rst) begin
      foreach (cnt_m[i]) cnt_m[i] = 1;
      ghr_m = 0;
    end else if (rdy) begin
      if (enable_from_rob)
        cnt_m[ti] = if_jump ? ((cnt_m[ti] < 3) ? cnt_m[ti] + 1 : 3)
                            : ((cnt_m[ti] > 0) ? cnt_m[ti] - 1 : 0);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      if (enable_from_rob && train_mispredict)
        ghr_m = ((int'(train_ghr) << 1) | int'(if_jump)) & 255;
      else if (fetch_valid && ins_cur[6:0] == 7'h63)
        ghr_m = ((ghr_m << 1) | int'(tk)) & 255;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pred(input string tag, input logic exp_tk, input logic [31:0] exp_pc);
    #2;
    check({tag, "_taken"}, 32'(predict_jump_to_dispatcher), 32'(exp_tk));
    check({tag, "_pc"}, pc_pred, exp_pc);
  endtask

  task automatic train(input logic [31:0] pc, input logic jump);
    enable_from_rob = 1'b1;
    train_pc        = pc;
    if_jump         = jump;
    tick();
    enable_from_rob = 1'b0;
  endtask

  initial begin
    logic        tk;
    logic [31:0] np;
    rst = 1'b1; rdy = 1'b1; pc_cur = 32'h100; ins_cur = BEQ; fetch_valid = 1'b0;
    enable_from_rob = 1'b0; if_jump = 1'b0; train_pc = 32'h0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    train_ghr = 8'h0; train_mispredict = 1'b0;
`endif
    foreach (cnt_m[i]) cnt_m[i] = 0;
    ghr_m = 0;
    #1;
    tick();
    rst = 1'b0;

    // reset state: weakly-not-taken
    expect_pred("reset_beq", 1'b0, 32'h104);
    train(32'h100, 1'b1);
    train(32'h100, 1'b1);
    expect_pred("trained_beq", 1'b1, 32'h108);
    train(32'h100, 1'b1);
    expect_pred("sat_high", 1'b1, 32'h108);
    train(32'h100, 1'b0);
    expect_pred("one_nt", 1'b1, 32'h108);
    train(32'h100, 1'b0);
    expect_pred("two_nt", 1'b0, 32'h104);
    train(32'h100, 1'b0);
    train(32'h100, 1'b0);
    train(32'h100, 1'b1);
    expect_pred("sat_low", 1'b0, 32'h104);

    // jal / jalr
    pc_cur = 32'h200; ins_cur = JAL;
    expect_pred("jal", 1'b1, 32'h1F8);
    ins_cur = JALR;
    expect_pred("jalr", 1'b0, 32'h204);

    // rdy=0 blocks training (counter currently 01)
    pc_cur = 32'h100; ins_cur = BEQ;
    rdy = 1'b0;
    train(32'h100, 1'b1);
    rdy = 1'b1;
    expect_pred("rdy_hold", 1'b0, 32'h104);

    // reset after saturating, with a simultaneous training write discarded
    train(32'h100, 1'b1);
    train(32'h100, 1'b1);
    expect_pred("pre_rst", 1'b1, 32'h108);
    rst = 1'b1;
    train(32'h100, 1'b1);
    rst = 1'b0;
    expect_pred("post_rst", 1'b0, 32'h104);

    // aliasing 0x100/0x500 and no bypass on same-cycle lookup
    enable_from_rob = 1'b1; train_pc = 32'h500; if_jump = 1'b1;
    expect_pred("same_cycle", 1'b0, 32'h104);
    tick();
    enable_from_rob = 1'b0;
    expect_pred("alias", 1'b1, 32'h108);
    pc_cur = 32'h500;
    expect_pred("alias_own", 1'b1, 32'h508);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    rst = 1'b1; tick(); rst = 1'b0;
    train(32'h100, 1'b1); train(32'h100, 1'b1);
    train(32'h104, 1'b1); train(32'h104, 1'b1);
    train(32'h10C, 1'b1); train(32'h10C, 1'b1);
    pc_cur = 32'h100; ins_cur = BEQ; fetch_valid = 1'b1;
    tick(); tick(); tick();
    #2;
    check("ghr_shift", 32'(pred_ghr), 32'h07);
    enable_from_rob = 1'b1; train_mispredict = 1'b1; train_ghr = 8'h01; if_jump = 1'b0;
    tick();
    enable_from_rob = 1'b0; train_mispredict = 1'b0; fetch_valid = 1'b0;
    #2;
    check("ghr_recover", 32'(pred_ghr), 32'h02);
`endif

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      int kind;
      rst         = ($urandom_range(0, 79) == 0);
      rdy         = ($urandom_range(0, 7) != 0);
      fetch_valid = $urandom_range(0, 1) != 0;
      pc_cur      = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFFFC) : ($urandom & 32'h7FC);
      kind        = $urandom_range(0, 4);
      ins_cur     = $urandom;
      if (kind <= 1)      ins_cur[6:0] = 7'b1100011;
      else if (kind == 2) ins_cur[6:0] = 7'b1101111;
      else if (kind == 3) ins_cur[6:0] = 7'b1100111;
      enable_from_rob = $urandom_range(0, 1) != 0;
      if_jump         = $urandom_range(0, 2) != 0;
      train_pc        = $urandom & 32'h7FC;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      train_ghr        = 8'($urandom);
      train_mispredict = ($urandom_range(0, 3) == 0);
`endif
      #2;
      model_pred(pc_cur, ins_cur, tk, np);
      check("rnd_taken", 32'(predict_jump_to_dispatcher), 32'(tk));
      check("rnd_pc", pc_pred, np);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      check("rnd_ghr", 32'(pred_ghr), 32'(ghr_m));
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised successor to the fixed pc+4 fetch predictor. Sits beside the instruction fetcher; presents next-PC and a taken flag for the instruction at pc_cur.
- Direction comes from a table of saturating counters indexed by PC; the ROB trains the table at commit.
- JAL is always predicted taken to its direct target. JALR and non-control instructions fall through to pc+4.

Parameters:
- ADDR_W, 32, PC width in bits.
- INS_W, 32, instruction width in bits.
- BHT_IDX_W, 8, log2 of table entries (default 256).
- CNT_W, 2, saturating counter width in bits; minimum 2.
- GHR_W, 8, global history length; used only with the optional feature; must be <= BHT_IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; when 0, all state holds
- pc_cur  in  ADDR_W  PC of instruction being fetched
- ins_cur  in  INS_W  instruction word at pc_cur
- fetch_valid  in  1  fetcher accepts ins_cur this cycle
- pc_pred  out  ADDR_W  predicted next PC
- predict_jump_to_dispatcher  out  1  predicted taken
- enable_from_rob  in  1  training strobe, one per committed B-type instruction
- if_jump  in  1  actual outcome of trained branch
- train_pc  in  ADDR_W  PC of trained branch
- pred_ghr  out  GHR_W  history snapshot for dispatcher (macro only)
- train_ghr  in  GHR_W  snapshot returned by ROB (macro only)
- train_mispredict  in  1  trained branch was mispredicted (macro only)

Behaviour:
- Decode on opcode ins_cur[6:0]:
  - 1101111 = JAL.
  - 1100011 = B-type.
  - All other opcodes, including JALR 1100111, are treated as non-control.
- Immediates: J and B immediates are sign-extended per the RV32I encoding. The sum with pc_cur wraps modulo 2^ADDR_W.
- Index: idx = pc[BHT_IDX_W+1:2]. With the macro, idx is XORed with the history (see Optional Feature).
- Prediction is combinational from pc_cur, ins_cur and current state:
  - JAL: taken=1, pc_pred = pc_cur + immJ.
  - B-type: taken = MSB of bht[idx]. pc_pred = pc_cur + immB if taken, else pc_cur + 4.
  - Other: taken=0, pc_pred = pc_cur + 4.
- Reset: on any clk edge with rst=1:
  - Every counter is set to weakly-not-taken, i.e. 2^(CNT_W-1)-1 (01 for CNT_W=2).
  - GHR is cleared to 0.
  - Outputs then follow combinationally from the reset state.
  - Reset during training discards that training write.
- Training: on a clk edge with rst=0, rdy=1 and enable_from_rob=1, the entry at the training index is updated:
  - Increment, saturating at 2^CNT_W-1, if if_jump=1.
  - Decrement, saturating at 0, if if_jump=0.
  - No wrap-around is permitted.
- Latency: the update is visible to prediction from the cycle after the edge.
- Same-cycle lookup and training of the same entry: the lookup sees the old value; there is no bypass.
- rdy=0: no table or GHR writes; enable_from_rob is ignored that cycle. Outputs remain combinational.
- Only one training write per cycle; the ROB guarantees this.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Enabled:
  - idx = pc[BHT_IDX_W+1:2] XOR zero-extended GHR.
  - Training uses train_pc XOR zero-extended train_ghr.
  - pred_ghr = current GHR.
  - GHR update on a clk edge with rdy=1 and rst=0, in priority order:
    1. enable_from_rob && train_mispredict: GHR <= {train_ghr[GHR_W-2:0], if_jump}. Recovery wins over a simultaneous speculative shift.
    2. Else, fetch_valid && B-type: GHR <= {GHR[GHR_W-2:0], predicted taken}.
    3. Else: hold.
- Disabled:
  - No GHR register and no pred_ghr, train_ghr or train_mispredict ports.
  - Pure bimodal indexing.

Test Plan:
- Reset then B-type 0x00000463 (beq, +8) at pc 0x100 -> taken=0, pc_pred=0x104 (counter 01).
- Train pc 0x100 taken twice -> counter 11. Next cycle the same beq -> taken=1, pc_pred=0x108. A third taken train keeps 11, then one not-taken train gives 10, still taken.
- JAL 0xFF9FF0EF (jal ra,-8) at pc 0x200 -> taken=1, pc_pred=0x1F8. JALR 0x000080E7 at 0x200 -> taken=0, pc_pred=0x204.
- Train pc 0x100 taken with rdy=0 -> counter unchanged, beq still predicts pc 0x104. Assert rst mid-sequence after counter reaches 11 -> beq predicts 0x104 next cycle.
- Aliasing: pc 0x100 and 0x500 (BHT_IDX_W=8) share idx 0x40. Training one flips the other's prediction. Same-cycle train+lookup of idx 0x40 shows the pre-update value.
- With BRANCH_PREDICTOR_GSHARE_EN:
  - Three predicted-taken fetch_valid branches take GHR 0 -> 0x07.
  - A mispredict train with train_ghr=0x01 and if_jump=0, simultaneous with a fetch_valid branch, gives GHR=0x02.
